// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbitration of execute/load results onto the register-file write port,
// with a pending-write scoreboard for decode hazard detection.
module wb_port_arbiter #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic            ex_valid,
  input  logic [AW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_data,
  output logic            ex_ready,
  input  logic            ld_valid,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [AW-1:0]   rs1_idx,
  input  logic [AW-1:0]   rs2_idx,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            wb_err
);
  logic            last_ld;
  logic [NREG-1:0] sb, sb_set, sb_clr;
  logic            grant;
  logic [AW-1:0]   g_rd;
  logic [XLEN-1:0] g_data;
  // the requester that lost the last grant wins a contention
  assign ex_ready = rst_n && ex_valid && (!ld_valid || last_ld);
  assign ld_ready = rst_n && ld_valid && (!ex_valid || !last_ld);
  assign grant    = ex_ready || ld_ready;
  assign g_rd     = ex_ready ? ex_rd : ld_rd;
  assign g_data   = ex_ready ? ex_data : ld_data;
  assign sb_set   = (iss_valid && iss_rd != '0) ? (NREG'(1) << iss_rd) : '0;
  assign sb_clr   = rf_we ? (NREG'(1) << rf_rd) : '0;
  assign rs1_busy = sb[rs1_idx];
  assign rs2_busy = sb[rs2_idx];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_ld  <= 1'b1;
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
      sb       <= '0;
      wb_err   <= 1'b0;
    end else begin
      last_ld  <= grant ? ld_ready : last_ld;
      rf_we    <= grant && g_rd != '0;
      if (grant) begin
        rf_rd    <= g_rd;
        rf_wdata <= g_data;
      end
      sb       <= ((sb & ~sb_clr) | sb_set) & ~NREG'(1);
      wb_err   <= wb_err | (rf_we && rf_rd != '0 && !sb[rf_rd]);
    end
  end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the execute-result path and the load-return path. It tracks in-flight destination registers in a scoreboard so that decode can detect read-after-write hazards. It sits between the execute/load units and the 32×64 register file, driving that file's RegWrite/rd/write_data inputs. Arbitration is round-robin, with at most one write per cycle.

## Interface
- XLEN, 64, data width of the register file
- NREG, 32, number of architectural registers; register 0 is hardwired zero
- AW, 5, register index width (log2 NREG)

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- iss_valid  in  1  decode issues an instruction that will write iss_rd
- iss_rd  in  AW  destination register of the issued instruction
- ex_valid  in  1  execute result pending
- ex_rd  in  AW  execute destination
- ex_data  in  XLEN  execute result
- ex_ready  out  1  execute result accepted this cycle
- ld_valid  in  1  load data pending
- ld_rd  in  AW  load destination
- ld_data  in  XLEN  load data
- ld_ready  out  1  load data accepted this cycle
- rf_we  out  1  register-file write enable (RegWrite)
- rf_rd  out  AW  register-file write index
- rf_wdata  out  XLEN  register-file write data
- rs1_idx, rs2_idx  in  AW  decode source indices
- rs1_busy, rs2_busy  out  1  the source has a pending write
- wb_err  out  1  sticky; set when a write retires to a register whose scoreboard bit is clear (index != 0)

## Operation
- **Grant:** a requester "fires" when valid && ready.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted last time wins.
  - The last-grant pointer updates only on a grant.
- **Readiness:** ex_ready and ld_ready are combinational.
  - They depend only on ex_valid, ld_valid and last_grant.
  - They are never both 1.
  - Both are 0 while rst_n = 0.
- **Write stage:** a granted request is registered into rf_we/rf_rd/rf_wdata.
  - If the granted rd = 0, the request is accepted (ready = 1) but rf_we = 0 the next cycle.
  - If nothing is granted, rf_we = 0 the next cycle; rf_rd and rf_wdata hold their values.
- **Scoreboard:** NREG bits; bit 0 is constant 0.
  - Set: iss_valid && iss_rd != 0 sets bit iss_rd at the clock edge.
  - Clear: rf_we clears bit rf_rd at the same edge the register file captures the data.
  - Same edge, same index: set wins, because the new instruction's write is pending.
- **Busy outputs:** rsN_busy = scoreboard[rsN_idx].
  - Combinational read of the registered bits.
  - No bypass: busy stays high through the cycle in which rf_we is asserted.
- **wb_err:** set when rf_we && rf_rd != 0 && scoreboard[rf_rd] == 0 at a clock edge. It clears only on reset.
- **Requester rules:** requesters must hold valid/rd/data stable until they fire. The arbiter does not check this.

## Timing
- **Reset values:** rf_we = 0, rf_rd = 0, rf_wdata = 0, all scoreboard bits 0, wb_err = 0, last_grant = LD (so execute wins the first contention).
- **Reset mid-operation:** pending grants are dropped and the scoreboard is cleared. rf_we = 0 in the cycle after rst_n rises.
- **Latency:**
  - Fire at cycle N gives rf_we = 1 in cycle N+1.
  - The register-file value is visible to reads from cycle N+2.
  - The scoreboard bit is clear in cycle N+2.
- **Throughput:** one write per cycle. Under continuous contention, grants alternate EX, LD, EX, ...
- **Issue vs. busy:** iss_valid at cycle N makes busy visible in cycle N+1. Issue and fire for the same register in the same cycle is legal: set, then clear one cycle later.

## Test plan
- **Reset:** assert rst_n = 0 with ex_valid = ld_valid = 1 → ex_ready = ld_ready = 0 and rf_we = 0. After release, the first contention grants EX.
- **Basic latency and scoreboard:** issue rd = 5 at cycle 0, then ex_valid with rd = 5 and data 0xDEADBEEF at cycle 2 →
  - ex_ready = 1 at cycle 2
  - rf_we = 1, rf_rd = 5, rf_wdata = 0xDEADBEEF at cycle 3
  - rs1_busy(5) = 1 in cycles 1–3 and 0 at cycle 4
- **Fairness:** hold ex_valid = ld_valid = 1 with distinct rd for 6 cycles → grant order EX, LD, EX, LD, EX, LD. Exactly 6 rf_we pulses; neither ready is high for 2 consecutive cycles.
- **x0 write:** ld_valid with rd = 0 and data 0x1234 → ld_ready = 1, next cycle rf_we = 0, scoreboard bit 0 stays 0, wb_err stays 0.
- **Set/clear collision:** register 7 pending, its write retires (rf_we, rf_rd = 7) in the same cycle iss_valid has iss_rd = 7 → bit 7 remains 1. A second write to 7 clears it, and wb_err = 0.
- **Spurious write:** ex_valid with rd = 9 and no prior issue → after retirement wb_err = 1, and it stays 1 until rst_n = 0.
